// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared widths, stall encoding and reset PC for the fetch stage
package if_stage_pkg;
  localparam int STALL_WD = 6;
  typedef logic [STALL_WD-1:0] StallBus;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam int BR_WD       = 33;
  localparam int IF_TO_ID_WD = 33;

  localparam logic [31:0] PC_RESET_VAL = 32'hbfbf_fffc;
endpackage

// File: rtl/if_inst_hold.sv
// rtl/if_inst_hold.sv - keeps the instruction word stable for decode while decode is stalled
module if_inst_hold
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] inst_to_id
);

  logic        hold_v;
  logic [31:0] inst_hold;

  // Capture only on the first stalled cycle; the SRAM output may move afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v    <= 1'b0;
      inst_hold <= 32'h0;
    end else if (stall_id == Stop) begin
      if (!hold_v) begin
        hold_v    <= 1'b1;
        inst_hold <= inst_sram_rdata;
      end
    end else begin
      hold_v <= 1'b0;
    end
  end

  assign inst_to_id = hold_v ? inst_hold : inst_sram_rdata;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC, next-PC select, pending branch, SRAM drive
// Optional misaligned-fetch detection under macro IF_ADEL_EN.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_VAL
) (
  input  logic                   clk,
  input  logic                   rst,
  input  StallBus                stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic [31:0]            inst_to_id,
  input  logic [31:0]            inst_sram_rdata,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  output logic                   if_adel
);

  logic        br_e;
  logic [31:0] br_addr;
  logic [31:0] pc_reg;
  logic        ce_reg;
  logic        br_pend_v;
  logic [31:0] br_pend_addr;
  logic [31:0] next_pc;
  logic [31:0] hold_inst;
  logic        unused_stall;

  assign br_e         = br_bus[32];
  assign br_addr      = br_bus[31:0];
  assign unused_stall = ^stall[STALL_WD-1:2];

  always_comb begin
    next_pc = pc_reg + 32'd4;
    if (br_e)
      next_pc = br_addr;
    else if (br_pend_v)
      next_pc = br_pend_addr;
  end

  // A branch arriving while the PC is frozen is parked until the first free edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg       <= PC_RESET;
      ce_reg       <= 1'b0;
      br_pend_v    <= 1'b0;
      br_pend_addr <= 32'h0;
    end else if (stall[0] == NoStop) begin
      pc_reg    <= next_pc;
      ce_reg    <= 1'b1;
      br_pend_v <= 1'b0;
    end else if (br_e) begin
      br_pend_v    <= 1'b1;
      br_pend_addr <= br_addr;
    end
  end

  if_inst_hold u_inst_hold (
    .clk             (clk),
    .rst             (rst),
    .stall_id        (stall[1]),
    .inst_sram_rdata (inst_sram_rdata),
    .inst_to_id      (hold_inst)
  );

`ifdef IF_ADEL_EN
  assign if_adel      = ce_reg & (pc_reg[1:0] != 2'b00);
  assign inst_sram_en = ce_reg & ~if_adel;
  assign inst_to_id   = if_adel ? 32'h0 : hold_inst;
`else
  assign if_adel      = 1'b0;
  assign inst_sram_en = ce_reg;
  assign inst_to_id   = hold_inst;
`endif

  assign if_to_id_bus    = {ce_reg, pc_reg};
  assign inst_sram_addr  = pc_reg;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed and randomized checks of if_stage against a reference model
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk;
  logic        rst;
  StallBus     stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic [31:0] inst_to_id;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        if_adel;

  int checks = 0;
  int errors = 0;

  // reference state: architectural view of the fetch stage
  logic [31:0] m_pc;
  logic        m_fetching;
  logic        m_have_target;
  logic [31:0] m_target;
  logic        m_frozen;
  logic [31:0] m_frozen_word;

  if_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_to_id      (inst_to_id),
    .inst_sram_rdata (inst_sram_rdata),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .if_adel         (if_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc          = 32'hbfbf_fffc;
    m_fetching    = 1'b0;
    m_have_target = 1'b0;
    m_target      = 32'h0;
    m_frozen      = 1'b0;
    m_frozen_word = 32'h0;
  endtask

  function automatic logic exp_adel();
`ifdef IF_ADEL_EN
    return m_fetching && (m_pc % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all();
    logic [31:0] word;
    word = m_frozen ? m_frozen_word : inst_sram_rdata;
    if (exp_adel()) word = 32'h0;
    chk("bus",   {31'h0, if_to_id_bus}, {31'h0, m_fetching, m_pc});
    chk("addr",  {32'h0, inst_sram_addr}, {32'h0, m_pc});
    chk("en",    {63'h0, inst_sram_en}, {63'h0, m_fetching && !exp_adel()});
    chk("inst",  {32'h0, inst_to_id}, {32'h0, word});
    chk("wen",   {60'h0, inst_sram_wen}, 64'h0);
    chk("wdata", {32'h0, inst_sram_wdata}, 64'h0);
    chk("adel",  {63'h0, if_adel}, {63'h0, exp_adel()});
  endtask

  // one clock edge worth of the fetch rules
  task automatic model_edge(input StallBus s, input logic be, input logic [31:0] ba, input logic [31:0] rd);
    if (!s[0]) begin
      if (be)                 m_pc = ba;
      else if (m_have_target) m_pc = m_target;
      else                    m_pc = m_pc + 32'd4;
      m_fetching    = 1'b1;
      m_have_target = 1'b0;
    end else if (be) begin
      m_have_target = 1'b1;
      m_target      = ba;
    end
    if (s[1] && !m_frozen) begin
      m_frozen      = 1'b1;
      m_frozen_word = rd;
    end else if (!s[1]) begin
      m_frozen = 1'b0;
    end
  endtask

  StallBus     cur_s;
  logic        cur_be;
  logic [31:0] cur_ba;
  logic [31:0] cur_rd;

  task automatic drive(input StallBus s, input logic be, input logic [31:0] ba, input logic [31:0] rd);
    @(negedge clk);
    stall = s; br_bus = {be, ba}; inst_sram_rdata = rd;
    cur_s = s; cur_be = be; cur_ba = ba; cur_rd = rd;
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge(cur_s, cur_be, cur_ba, cur_rd);
  endtask

  task automatic cyc(input StallBus s, input logic be, input logic [31:0] ba, input logic [31:0] rd);
    drive(s, be, ba, rd);
    tick();
  endtask

  initial begin
    rst = 1'b1; stall = '0; br_bus = '0; inst_sram_rdata = 32'h0;
    model_reset();

    // reset state, then release with no stall
    drive(6'h0, 1'b0, 32'h0, 32'h1111_2222);
    chk("rst_bus", {31'h0, if_to_id_bus}, {31'h0, 1'b0, 32'hbfbf_fffc});
    chk("rst_en", {63'h0, inst_sram_en}, 64'h0);
    rst = 1'b0;
    tick();
    drive(6'h0, 1'b0, 32'h0, $urandom);
    chk("seq0", {32'h0, inst_sram_addr}, {32'h0, 32'hbfc0_0000});
    chk("ce_up", {63'h0, if_to_id_bus[32]}, 64'h1);
    tick();
    cyc(6'h0, 1'b0, 32'h0, $urandom);
    drive(6'h0, 1'b0, 32'h0, $urandom);
    chk("seq2", {32'h0, inst_sram_addr}, {32'h0, 32'hbfc0_0008});
    tick();

    // live branch
    cyc(6'h0, 1'b1, 32'hbfc0_0100, $urandom);
    drive(6'h0, 1'b0, 32'h0, $urandom);
    chk("br_n1", {32'h0, inst_sram_addr}, {32'h0, 32'hbfc0_0100});
    tick();
    drive(6'h0, 1'b0, 32'h0, $urandom);
    chk("br_n2", {32'h0, inst_sram_addr}, {32'h0, 32'hbfc0_0104});
    tick();

    // branch during a 3-cycle PC stall
    cyc(6'h1, 1'b1, 32'hbfc0_0200, $urandom);
    cyc(6'h1, 1'b0, 32'h0, $urandom);
    drive(6'h1, 1'b0, 32'h0, $urandom);
    chk("stall_hold", {32'h0, inst_sram_addr}, {32'h0, 32'hbfc0_0108});
    tick();
    cyc(6'h0, 1'b0, 32'h0, $urandom);
    drive(6'h0, 1'b0, 32'h0, $urandom);
    chk("pend_br", {32'h0, inst_sram_addr}, {32'h0, 32'hbfc0_0200});
    tick();

    // live branch overrides pending on release edge
    cyc(6'h1, 1'b1, 32'hbfc0_0300, $urandom);
    cyc(6'h0, 1'b1, 32'hbfc0_0400, $urandom);
    drive(6'h0, 1'b0, 32'h0, $urandom);
    chk("live_wins", {32'h0, inst_sram_addr}, {32'h0, 32'hbfc0_0400});
    tick();

    // decode stall holds the instruction word
    cyc(6'h2, 1'b0, 32'h0, 32'h2408_0001);
    drive(6'h2, 1'b0, 32'h0, 32'hdead_beef);
    chk("hold1", {32'h0, inst_to_id}, {32'h0, 32'h2408_0001});
    tick();
    drive(6'h0, 1'b0, 32'h0, 32'hdead_beef);
    chk("hold_rel", {32'h0, inst_to_id}, {32'h0, 32'h2408_0001});
    tick();
    drive(6'h0, 1'b0, 32'h0, 32'hdead_beef);
    chk("hold_clr", {32'h0, inst_to_id}, {32'h0, 32'hdead_beef});
    tick();

    // mid-run reset with pending branch and held word
    cyc(6'h3, 1'b1, 32'hbfc0_0500, 32'h1234_5678);
    drive(6'h3, 1'b0, 32'h0, 32'h9abc_def0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("mrst_bus", {31'h0, if_to_id_bus}, {31'h0, 1'b0, 32'hbfbf_fffc});
    chk("mrst_inst", {32'h0, inst_to_id}, {32'h0, 32'h9abc_def0});
    tick();
    drive(6'h0, 1'b0, 32'h0, $urandom);
    rst = 1'b0;
    tick();
    drive(6'h0, 1'b0, 32'h0, $urandom);
    chk("mrst_fetch", {32'h0, inst_sram_addr}, {32'h0, 32'hbfc0_0000});
    tick();

    // misaligned branch target
    cyc(6'h0, 1'b1, 32'hbfc0_0102, $urandom);
    drive(6'h0, 1'b0, 32'h0, 32'h5555_aaaa);
`ifdef IF_ADEL_EN
    chk("adel_flag", {63'h0, if_adel}, 64'h1);
    chk("adel_en", {63'h0, inst_sram_en}, 64'h0);
    chk("adel_inst", {32'h0, inst_to_id}, 64'h0);
`else
    chk("noadel_flag", {63'h0, if_adel}, 64'h0);
    chk("noadel_en", {63'h0, inst_sram_en}, 64'h1);
`endif
    tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      StallBus     s;
      logic        be;
      logic [31:0] ba;
      s  = StallBus'($urandom);
      s[0] = ($urandom_range(0, 3) == 0);
      s[1] = ($urandom_range(0, 3) == 0);
      be = ($urandom_range(0, 4) == 0);
      ba = $urandom;
      if ($urandom_range(0, 7) != 0) ba[1:0] = 2'b00;
      if (i == 200) begin
        drive(s, be, ba, $urandom);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        rst = 1'b0;
      end else begin
        cyc(s, be, ba, $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
